// File: rtl/calib_pkg.sv
// Calibration state encoding and default timing shared by the sequencer and display decode.
// Pure types/constants: no latency, no flow control.
package calib_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ARM    = 3'd2,
        ST_PING   = 3'd3,
        ST_LISTEN = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } calib_state_t;

    localparam int                 CAL_SETTLE_SAMPLES  = 4800;
    localparam int                 CAL_PING_SAMPLES    = 48;
    localparam int                 CAL_TIMEOUT_SAMPLES = 96000;
    localparam logic signed [15:0] CAL_PING_AMPLITUDE  = 16'sh4000;

    // A new calibration may only begin from a resting state.
    function automatic logic can_start(input calib_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/calibration_sequencer_if.sv
// Control/status bundle between the calibration sequencer and its buttons/recorder/speaker mux.
// Level/strobe signals only; no handshake, every output is a registered level or 1-cycle pulse.
interface calibration_sequencer_if;
    import calib_pkg::*;

    logic               audio_trigger;
    logic               start_in;
    logic               abort_in;
    logic [7:0]         delay_in;
    logic               impulse_recorded;

    logic [7:0]         delay_out;
    logic               record_trigger_out;
    logic signed [15:0] ping_out;
    logic               ping_active_out;
    logic               mute_out;
    logic               convolve_enable_out;
    logic               done_out;
    logic               error_out;
    calib_state_t       state_out;

    modport master (
        output audio_trigger, start_in, abort_in, delay_in, impulse_recorded,
        input  delay_out, record_trigger_out, ping_out, ping_active_out, mute_out,
               convolve_enable_out, done_out, error_out, state_out
    );

    modport slave (
        input  audio_trigger, start_in, abort_in, delay_in, impulse_recorded,
        output delay_out, record_trigger_out, ping_out, ping_active_out, mute_out,
               convolve_enable_out, done_out, error_out, state_out
    );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector: remembers last level, rise is high the cycle the input goes 0->1.
// Zero-cycle detect from the registered history; no backpressure.
module rise_detect (
    input  logic audio_clk,
    input  logic rst_in,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/calibration_sequencer.sv
// Runs one room-impulse calibration (mute, settle, arm recorder, ping, listen) and gates convolution.
// All outputs registered, one cycle after the deciding input; abort wins over everything but reset.
module calibration_sequencer
    import calib_pkg::*;
#(
    parameter int                 SETTLE_SAMPLES  = CAL_SETTLE_SAMPLES,
    parameter int                 PING_SAMPLES    = CAL_PING_SAMPLES,
    parameter logic signed [15:0] PING_AMPLITUDE  = CAL_PING_AMPLITUDE,
    parameter int                 TIMEOUT_SAMPLES = CAL_TIMEOUT_SAMPLES
) (
    input logic                    audio_clk,
    input logic                    rst_in,
    calibration_sequencer_if.slave seq
);

    localparam int SMP_MAX = (SETTLE_SAMPLES > PING_SAMPLES) ? SETTLE_SAMPLES : PING_SAMPLES;
    localparam int SMP_W   = $clog2(SMP_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT_SAMPLES + 1);

    localparam logic [SMP_W-1:0] SETTLE_LAST = SMP_W'(SETTLE_SAMPLES - 1);
    localparam logic [SMP_W-1:0] PING_LAST   = SMP_W'(PING_SAMPLES - 1);
    localparam logic [SMP_W-1:0] SMP_SAT     = SMP_W'(SMP_MAX);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_SAMPLES - 1);
    localparam logic [TO_W-1:0]  TO_SAT      = TO_W'(TIMEOUT_SAMPLES);

    calib_state_t       state_q;
    logic [SMP_W-1:0]   smp_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               ir_seen;
    logic [7:0]         delay_q;
    logic               rec_trig_q;
    logic signed [15:0] ping_q;
    logic               ping_act_q;
    logic               mute_q;
    logic               conv_q;
    logic               done_q;
    logic               err_q;

    logic start_rise;
    logic ir_rise;
    logic to_hit;
    logic to_inc;

    rise_detect u_start_rise (
        .audio_clk (audio_clk),
        .rst_in    (rst_in),
        .level     (seq.start_in),
        .rise      (start_rise)
    );

    rise_detect u_ir_rise (
        .audio_clk (audio_clk),
        .rst_in    (rst_in),
        .level     (seq.impulse_recorded),
        .rise      (ir_rise)
    );

    // Timeout fires on the trigger that would bring the count to TIMEOUT_SAMPLES.
    assign to_inc = seq.audio_trigger && (to_cnt != TO_SAT);
    assign to_hit = (to_cnt == TO_SAT) || (seq.audio_trigger && (to_cnt == TO_LAST));

    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            smp_cnt    <= '0;
            to_cnt     <= '0;
            ir_seen    <= 1'b0;
            delay_q    <= 8'h00;
            rec_trig_q <= 1'b0;
            ping_q     <= 16'sh0000;
            ping_act_q <= 1'b0;
            mute_q     <= 1'b0;
            conv_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rec_trig_q <= 1'b0;
            if (seq.abort_in) begin
                // Status of the last run survives an abort; only the live outputs drop.
                state_q    <= ST_IDLE;
                ping_q     <= 16'sh0000;
                ping_act_q <= 1'b0;
                mute_q     <= 1'b0;
                conv_q     <= 1'b0;
            end else if (start_rise && can_start(state_q)) begin
                state_q <= ST_SETTLE;
                delay_q <= seq.delay_in;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                conv_q  <= 1'b0;
                mute_q  <= 1'b1;
                smp_cnt <= '0;
            end else begin
                case (state_q)
                    ST_SETTLE: begin
                        if (seq.audio_trigger) begin
                            if (smp_cnt == SETTLE_LAST) begin
                                state_q    <= ST_ARM;
                                rec_trig_q <= 1'b1;
                            end else if (smp_cnt != SMP_SAT) begin
                                smp_cnt <= smp_cnt + SMP_W'(1);
                            end
                        end
                    end
                    ST_ARM: begin
                        // A level already high here is not an edge; only later rises count.
                        state_q    <= ST_PING;
                        smp_cnt    <= '0;
                        to_cnt     <= '0;
                        ir_seen    <= 1'b0;
                        ping_q     <= PING_AMPLITUDE;
                        ping_act_q <= 1'b1;
                    end
                    ST_PING: begin
                        if (ir_rise) begin
                            ir_seen <= 1'b1;
                        end
                        if (to_inc) begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                        if (to_hit) begin
                            state_q    <= ST_ERROR;
                            err_q      <= 1'b1;
                            conv_q     <= 1'b0;
                            mute_q     <= 1'b0;
                            ping_q     <= 16'sh0000;
                            ping_act_q <= 1'b0;
                        end else if (seq.audio_trigger) begin
                            if (smp_cnt == PING_LAST) begin
                                state_q    <= ST_LISTEN;
                                ping_q     <= 16'sh0000;
                                ping_act_q <= 1'b0;
                            end else if (smp_cnt != SMP_SAT) begin
                                smp_cnt <= smp_cnt + SMP_W'(1);
                            end
                        end
                    end
                    ST_LISTEN: begin
                        if (to_inc) begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                        // A capture edge beats a coincident timeout.
                        if (ir_rise || ir_seen) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            conv_q  <= 1'b1;
                            mute_q  <= 1'b0;
                        end else if (to_hit) begin
                            state_q <= ST_ERROR;
                            err_q   <= 1'b1;
                            conv_q  <= 1'b0;
                            mute_q  <= 1'b0;
                        end
                    end
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign seq.delay_out           = delay_q;
    assign seq.record_trigger_out  = rec_trig_q;
    assign seq.ping_out            = ping_q;
    assign seq.ping_active_out     = ping_act_q;
    assign seq.mute_out            = mute_q;
    assign seq.convolve_enable_out = conv_q;
    assign seq.done_out            = done_q;
    assign seq.error_out           = err_q;
    assign seq.state_out           = state_q;

endmodule

// File: tb/tb_calibration_sequencer.sv
// Directed bench for calibration_sequencer with SETTLE=4, PING=2, TIMEOUT=20, trigger every 8 clocks.
module tb_calibration_sequencer;
    import calib_pkg::*;

    logic audio_clk;
    logic rst_in;
    int   tests = 0;
    int   fails = 0;
    int   phase = 0;

    calibration_sequencer_if seq ();

    calibration_sequencer #(
        .SETTLE_SAMPLES  (4),
        .PING_SAMPLES    (2),
        .PING_AMPLITUDE  (16'sh4000),
        .TIMEOUT_SAMPLES (20)
    ) dut (
        .audio_clk (audio_clk),
        .rst_in    (rst_in),
        .seq       (seq)
    );

    initial audio_clk = 1'b0;
    always #5 audio_clk = ~audio_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; the sample strobe is high one cycle in every eight.
    task automatic tick();
        @(posedge audio_clk);
        #1;
        phase = (phase == 7) ? 0 : phase + 1;
        seq.audio_trigger = (phase == 7);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until n triggers have been sampled by the DUT.
    task automatic consume(input int n);
        for (int k = 0; k < n; k++) begin
            while (!seq.audio_trigger) tick();
            tick();
        end
    endtask

    initial begin
        rst_in               = 1'b0;
        seq.audio_trigger    = 1'b0;
        seq.start_in         = 1'b0;
        seq.abort_in         = 1'b0;
        seq.delay_in         = 8'd0;
        seq.impulse_recorded = 1'b0;
        ticks(3);

        check("rst_state",  32'(seq.state_out),           32'(ST_IDLE));
        check("rst_ping",   32'(seq.ping_out),            32'h0);
        check("rst_pact",   32'(seq.ping_active_out),     32'h0);
        check("rst_mute",   32'(seq.mute_out),            32'h0);
        check("rst_rec",    32'(seq.record_trigger_out),  32'h0);
        check("rst_conv",   32'(seq.convolve_enable_out), 32'h0);
        check("rst_done",   32'(seq.done_out),            32'h0);
        check("rst_err",    32'(seq.error_out),           32'h0);
        check("rst_delay",  32'(seq.delay_out),           32'h0);
        rst_in = 1'b1;
        tick();

        // Full successful run with delay 12
        seq.delay_in = 8'd12;
        seq.start_in = 1'b1;
        tick();
        check("t1_settle",  32'(seq.state_out),  32'(ST_SETTLE));
        check("t1_delay",   32'(seq.delay_out),  32'd12);
        check("t1_mute",    32'(seq.mute_out),   32'h1);
        seq.start_in = 1'b0;
        consume(3);
        check("t1_settle3", 32'(seq.state_out),  32'(ST_SETTLE));
        consume(1);
        check("t1_arm",     32'(seq.state_out),           32'(ST_ARM));
        check("t1_rec",     32'(seq.record_trigger_out),  32'h1);
        tick();
        check("t1_ping",    32'(seq.state_out),           32'(ST_PING));
        check("t1_rec_off", 32'(seq.record_trigger_out),  32'h0);
        check("t1_pamp",    32'(seq.ping_out),            32'h4000);
        check("t1_pact",    32'(seq.ping_active_out),     32'h1);
        consume(1);
        check("t1_ping1",   32'(seq.ping_out),            32'h4000);
        consume(1);
        check("t1_listen",  32'(seq.state_out),           32'(ST_LISTEN));
        check("t1_pzero",   32'(seq.ping_out),            32'h0);
        check("t1_pact0",   32'(seq.ping_active_out),     32'h0);
        check("t1_lmute",   32'(seq.mute_out),            32'h1);
        consume(2);
        seq.delay_in = 8'd40;
        tick();
        check("t4_delay_hold", 32'(seq.delay_out),        32'd12);
        seq.impulse_recorded = 1'b1;
        tick();
        check("t1_done",    32'(seq.state_out),           32'(ST_DONE));
        check("t1_done_o",  32'(seq.done_out),            32'h1);
        check("t1_conv",    32'(seq.convolve_enable_out), 32'h1);
        check("t1_unmute",  32'(seq.mute_out),            32'h0);
        check("t1_noerr",   32'(seq.error_out),           32'h0);
        check("t1_delay12", 32'(seq.delay_out),           32'd12);
        ticks(5);
        check("t1_hold",    32'(seq.state_out),           32'(ST_DONE));

        // Restart from DONE: convolve drops as SETTLE is entered; impulse stays high
        seq.start_in = 1'b1;
        tick();
        check("t4_settle",  32'(seq.state_out),           32'(ST_SETTLE));
        check("t4_conv0",   32'(seq.convolve_enable_out), 32'h0);
        check("t4_done0",   32'(seq.done_out),            32'h0);
        check("t4_delay40", 32'(seq.delay_out),           32'd40);
        seq.start_in = 1'b0;
        consume(4);
        check("t2_arm",     32'(seq.state_out),           32'(ST_ARM));
        consume(19);
        check("t2_listen",  32'(seq.state_out),           32'(ST_LISTEN));
        check("t2_nodone",  32'(seq.done_out),            32'h0);
        consume(1);
        check("t2_error",   32'(seq.state_out),           32'(ST_ERROR));
        check("t2_err_o",   32'(seq.error_out),           32'h1);
        check("t2_conv0",   32'(seq.convolve_enable_out), 32'h0);
        check("t2_unmute",  32'(seq.mute_out),            32'h0);
        ticks(4);
        check("t2_hold",    32'(seq.state_out),           32'(ST_ERROR));

        // Abort during PING with a coincident start edge
        seq.impulse_recorded = 1'b0;
        seq.start_in = 1'b1;
        tick();
        check("t3_settle",  32'(seq.state_out),           32'(ST_SETTLE));
        check("t3_err0",    32'(seq.error_out),           32'h0);
        seq.start_in = 1'b0;
        consume(4);
        tick();
        check("t3_ping",    32'(seq.state_out),           32'(ST_PING));
        seq.abort_in = 1'b1;
        seq.start_in = 1'b1;
        tick();
        check("t3_idle",    32'(seq.state_out),           32'(ST_IDLE));
        check("t3_ping0",   32'(seq.ping_out),            32'h0);
        check("t3_pact0",   32'(seq.ping_active_out),     32'h0);
        check("t3_mute0",   32'(seq.mute_out),            32'h0);
        seq.abort_in = 1'b0;
        ticks(3);
        check("t3_stay",    32'(seq.state_out),           32'(ST_IDLE));

        // Capture edge on the same trigger that would time out
        seq.start_in = 1'b0;
        tick();
        seq.start_in = 1'b1;
        tick();
        check("t6_settle",  32'(seq.state_out),           32'(ST_SETTLE));
        seq.start_in = 1'b0;
        consume(4);
        consume(19);
        check("t6_listen",  32'(seq.state_out),           32'(ST_LISTEN));
        while (!seq.audio_trigger) tick();
        seq.impulse_recorded = 1'b1;
        tick();
        check("t6_done",    32'(seq.state_out),           32'(ST_DONE));
        check("t6_noerr",   32'(seq.error_out),           32'h0);
        check("t6_done_o",  32'(seq.done_out),            32'h1);

        // Asynchronous reset in the middle of PING
        seq.impulse_recorded = 1'b0;
        seq.start_in = 1'b1;
        tick();
        check("t5_settle",  32'(seq.state_out),           32'(ST_SETTLE));
        seq.start_in = 1'b0;
        consume(4);
        tick();
        check("t5_pamp",    32'(seq.ping_out),            32'h4000);
        #2;
        rst_in = 1'b0;
        #1;
        check("t5_ping0",   32'(seq.ping_out),            32'h0);
        check("t5_pact0",   32'(seq.ping_active_out),     32'h0);
        check("t5_state0",  32'(seq.state_out),           32'(ST_IDLE));
        check("t5_mute0",   32'(seq.mute_out),            32'h0);
        check("t5_done0",   32'(seq.done_out),            32'h0);
        tick();
        rst_in = 1'b1;
        tick();
        check("t5_idle",    32'(seq.state_out),           32'(ST_IDLE));
        seq.delay_in = 8'd7;
        seq.start_in = 1'b1;
        tick();
        check("t5_restart", 32'(seq.state_out),           32'(ST_SETTLE));
        check("t5_delay7",  32'(seq.delay_out),           32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
